// File: rtl/v_hier_subsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : v_hier_subsub_pipe
// Purpose  : Leaf pipeline of the example hierarchy. Carries a signed or
//            unsigned value through DEPTH elastic register stages with a
//            valid/ready handshake on both sides. Each value is width-
//            converted (extend, truncate or saturate) before stage 0.
// Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1              rising-edge clock
//   reset_l    in   1              asynchronous active-low reset
//   flush      in   1              synchronous clear of all stage valids
//   in_valid   in   1              a is valid this cycle
//   in_ready   out  1              block accepts a this cycle
//   a          in   WIDTH          input data
//   out_valid  out  1              q is valid
//   out_ready  in   1              consumer accepts q this cycle
//   q          out  OUT_WIDTH      output data (last stage)
//   count      out  clog2(DEPTH+1) number of occupied stages
// ============================================================================
module v_hier_subsub_pipe #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 2,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 0
) (
  input  logic                         clk,
  input  logic                         reset_l,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     r_v;
  logic [OUT_WIDTH-1:0] r_d     [DEPTH];
  logic [CNT_W-1:0]     r_count;

  logic [DEPTH-1:0]     w_rdy;
  logic                 w_rdy_acc;
  logic [DEPTH-1:0]     w_src_v;
  logic [OUT_WIDTH-1:0] w_src_d [DEPTH];
  logic [OUT_WIDTH-1:0] w_conv;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

  // --------------------------------------------------------------------------
  // Width conversion of the incoming value
  // --------------------------------------------------------------------------
  generate
    if (OUT_WIDTH >= WIDTH) begin : g_extend
      if (SIGNED != 0) begin : g_sext
        assign w_conv = OUT_WIDTH'(signed'(a));
      end else begin : g_zext
        assign w_conv = OUT_WIDTH'(a);
      end
    end else begin : g_narrow
      if (SATURATE == 0) begin : g_trunc
        logic w_unused_hi;
        assign w_unused_hi = ^a[WIDTH-1:OUT_WIDTH];
        assign w_conv      = a[OUT_WIDTH-1:0];
      end else if (SIGNED != 0) begin : g_ssat
        // The value fits when every bit from the output sign bit upward
        // agrees with the input sign bit.
        logic [WIDTH-OUT_WIDTH:0] w_top;
        logic                     w_fits;
        logic [OUT_WIDTH-1:0]     w_clamp;
        assign w_top  = a[WIDTH-1:OUT_WIDTH-1];
        assign w_fits = (&w_top) | ~(|w_top);
        // Negative overflow -> 100..0, positive overflow -> 011..1.
        always_comb begin
          w_clamp                = {OUT_WIDTH{~a[WIDTH-1]}};
          w_clamp[OUT_WIDTH-1]   = a[WIDTH-1];
        end
        assign w_conv = w_fits ? a[OUT_WIDTH-1:0] : w_clamp;
      end else begin : g_usat
        assign w_conv = (|a[WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                : a[OUT_WIDTH-1:0];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Ready chain: a stage can load when it is empty or everything downstream
  // of it can move. Computed as a running OR from the output side so there
  // is no self-referencing vector.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdy     = '0;
    w_rdy_acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_rdy_acc = w_rdy_acc | ~r_v[k];
      w_rdy[k]  = w_rdy_acc;
    end
  end

  assign in_ready   = w_rdy[0] & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = r_v[DEPTH-1];
  assign q          = r_d[DEPTH-1];
  assign w_out_xfer = out_valid & out_ready;
  assign count      = r_count;

  // --------------------------------------------------------------------------
  // Per-stage source selection
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
      if (k == 0) begin : g_head
        assign w_src_v[k] = w_in_xfer;
        assign w_src_d[k] = w_conv;
      end else begin : g_body
        assign w_src_v[k] = r_v[k-1];
        assign w_src_d[k] = r_d[k-1];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage registers. Flush clears only the valid bits; data is left as-is.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          r_v[k] <= 1'b0;
        end else if (w_rdy[k]) begin
          r_v[k] <= w_src_v[k];
        end
        if (w_rdy[k] && w_src_v[k]) begin
          r_d[k] <= w_src_d[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy counter. A simultaneous in and out transfer leaves it as is;
  // a flush discards everything, including an output handshake in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_v_hier_subsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_hier_subsub_pipe
// Purpose  : Directed self-checking bench for v_hier_subsub_pipe. One
//            DEPTH=2 instance exercises handshake, flush and reset; five
//            DEPTH=1 instances exercise the width-conversion modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_hier_subsub_pipe;

  logic       clk;
  logic       reset_l;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [1:0] count;

  // conversion instances share these inputs
  logic       cv_valid;
  logic       cv_ready;
  logic       cv_flush;
  logic [7:0] cv_a8;
  logic [3:0] cv_a4;

  logic       ssat_ir, ssat_ov, trunc_ir, trunc_ov, usat_ir, usat_ov;
  logic       sext_ir, sext_ov, zext_ir, zext_ov;
  logic [3:0] ssat_q, trunc_q, usat_q;
  logic [7:0] sext_q, zext_q;
  logic       ssat_cnt, trunc_cnt, usat_cnt, sext_cnt, zext_cnt;

  int n_cmp;
  int n_bad;

  v_hier_subsub_pipe #(.WIDTH(8), .OUT_WIDTH(8), .DEPTH(2), .SIGNED(1), .SATURATE(0)) u_dut (
    .clk(clk), .reset_l(reset_l), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count));

  v_hier_subsub_pipe #(.WIDTH(8), .OUT_WIDTH(4), .DEPTH(1), .SIGNED(1), .SATURATE(1)) u_ssat (
    .clk(clk), .reset_l(reset_l), .flush(cv_flush), .in_valid(cv_valid), .in_ready(ssat_ir),
    .a(cv_a8), .out_valid(ssat_ov), .out_ready(cv_ready), .q(ssat_q), .count(ssat_cnt));

  v_hier_subsub_pipe #(.WIDTH(8), .OUT_WIDTH(4), .DEPTH(1), .SIGNED(1), .SATURATE(0)) u_trunc (
    .clk(clk), .reset_l(reset_l), .flush(cv_flush), .in_valid(cv_valid), .in_ready(trunc_ir),
    .a(cv_a8), .out_valid(trunc_ov), .out_ready(cv_ready), .q(trunc_q), .count(trunc_cnt));

  v_hier_subsub_pipe #(.WIDTH(8), .OUT_WIDTH(4), .DEPTH(1), .SIGNED(0), .SATURATE(1)) u_usat (
    .clk(clk), .reset_l(reset_l), .flush(cv_flush), .in_valid(cv_valid), .in_ready(usat_ir),
    .a(cv_a8), .out_valid(usat_ov), .out_ready(cv_ready), .q(usat_q), .count(usat_cnt));

  v_hier_subsub_pipe #(.WIDTH(4), .OUT_WIDTH(8), .DEPTH(1), .SIGNED(1), .SATURATE(0)) u_sext (
    .clk(clk), .reset_l(reset_l), .flush(cv_flush), .in_valid(cv_valid), .in_ready(sext_ir),
    .a(cv_a4), .out_valid(sext_ov), .out_ready(cv_ready), .q(sext_q), .count(sext_cnt));

  v_hier_subsub_pipe #(.WIDTH(4), .OUT_WIDTH(8), .DEPTH(1), .SIGNED(0), .SATURATE(0)) u_zext (
    .clk(clk), .reset_l(reset_l), .flush(cv_flush), .in_valid(cv_valid), .in_ready(zext_ir),
    .a(cv_a4), .out_valid(zext_ov), .out_ready(cv_ready), .q(zext_q), .count(zext_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one conversion vector through the DEPTH=1 instances
  task automatic conv8(input logic [7:0] v, input logic [3:0] e_ssat,
                       input logic [3:0] e_trunc, input logic [3:0] e_usat);
    cv_a8 = v;
    step();
    check_val($sformatf("ssat_%02h", v),  32'(ssat_q),  32'(e_ssat));
    check_val($sformatf("trunc_%02h", v), 32'(trunc_q), 32'(e_trunc));
    check_val($sformatf("usat_%02h", v),  32'(usat_q),  32'(e_usat));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_l   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    cv_valid  = 1'b0;
    cv_ready  = 1'b1;
    cv_flush  = 1'b0;
    cv_a8     = '0;
    cv_a4     = '0;

    // ---------------- reset state ----------------
    step();
    step();
    check_val("rst_q",     32'(q),         32'h0);
    check_val("rst_ovld",  32'(out_valid), 32'h0);
    check_val("rst_count", 32'(count),     32'h0);
    reset_l = 1'b1;
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'h1);

    // ---------------- width conversion (DEPTH=1) ----------------
    cv_valid = 1'b1;
    conv8(8'h7F, 4'h7, 4'hF, 4'hF);
    check_val("d1_ovld",  32'(ssat_ov),  32'h1);
    check_val("d1_count", 32'(ssat_cnt), 32'h1);
    conv8(8'h80, 4'h8, 4'h0, 4'hF);
    conv8(8'hFE, 4'hE, 4'hE, 4'hF);
    conv8(8'h05, 4'h5, 4'h5, 4'h5);
    cv_a4 = 4'hA;
    step();
    check_val("sext_A", 32'(sext_q), 32'hFA);
    check_val("zext_A", 32'(zext_q), 32'h0A);
    cv_a4 = 4'h5;
    step();
    check_val("sext_5", 32'(sext_q), 32'h05);
    check_val("zext_5", 32'(zext_q), 32'h05);
    cv_valid = 1'b0;
    step();
    check_val("d1_drain", 32'(ssat_ov), 32'h0);

    // ---------------- streaming 1,2,3 ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'd1;
    step();
    check_val("str_c0_count", 32'(count),     32'd1);
    check_val("str_c0_ovld",  32'(out_valid), 32'h0);
    a = 8'd2;
    step();
    check_val("str_c1_ovld",  32'(out_valid), 32'h1);
    check_val("str_c1_q",     32'(q),         32'd1);
    check_val("str_c1_count", 32'(count),     32'd2);
    a = 8'd3;
    step();
    check_val("str_c2_q",     32'(q),         32'd2);
    check_val("str_c2_count", 32'(count),     32'd2);
    in_valid = 1'b0;
    step();
    check_val("str_c3_q",     32'(q),         32'd3);
    check_val("str_c3_count", 32'(count),     32'd1);
    step();
    check_val("str_c4_ovld",  32'(out_valid), 32'h0);
    check_val("str_c4_count", 32'(count),     32'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h11;
    step();
    a = 8'h22;
    step();
    a = 8'h33;
    #1;
    check_val("bp_full_ready", 32'(in_ready), 32'h0);
    check_val("bp_full_count", 32'(count),    32'd2);
    check_val("bp_full_q",     32'(q),        32'h11);
    step();
    check_val("bp_hold_q",     32'(q),         32'h11);
    check_val("bp_hold_ovld",  32'(out_valid), 32'h1);
    check_val("bp_hold_count", 32'(count),     32'd2);
    out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    check_val("bp_q2",     32'(q),     32'h22);
    check_val("bp_count2", 32'(count), 32'd2);
    in_valid = 1'b0;
    step();
    check_val("bp_q3",     32'(q),     32'h33);
    check_val("bp_count3", 32'(count), 32'd1);

    // ---------------- flush ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h44;
    step();
    check_val("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1;
    a     = 8'h55;
    #1;
    check_val("fl_in_ready", 32'(in_ready), 32'h0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("fl_count", 32'(count),     32'd0);
    check_val("fl_ovld",  32'(out_valid), 32'h0);
    out_ready = 1'b1;
    step();
    step();
    check_val("fl_nostore_ovld",  32'(out_valid), 32'h0);
    check_val("fl_nostore_count", 32'(count),     32'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h66;
    step();
    a = 8'h77;
    step();
    in_valid = 1'b0;
    check_val("ar_pre_count", 32'(count), 32'd2);
    #2;
    reset_l = 1'b0;
    #1;
    check_val("ar_q",     32'(q),         32'h0);
    check_val("ar_ovld",  32'(out_valid), 32'h0);
    check_val("ar_count", 32'(count),     32'd0);
    step();
    reset_l = 1'b1;
    #1;
    check_val("ar_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hA5;
    step();
    in_valid = 1'b0;
    step();
    check_val("ar_first_q",    32'(q),         32'hA5);
    check_val("ar_first_ovld", 32'(out_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
